// File: rtl/sobel_stream_core_if.sv
// Stream bundle for sobel_stream_core: raster pixel input, gradient output with frame
// flags, and the per-pixel output-mode controls.
interface sobel_stream_core_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_pix;
  logic              mode;
  logic [DATA_W-1:0] thresh;
  logic              out_valid;
  logic [DATA_W-1:0] out_pix;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output in_valid, in_sof, in_pix, mode, thresh,
    input  out_valid, out_pix, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_pix, mode, thresh,
    output out_valid, out_pix, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge core: two line buffers feed a shifting window; gradient
// magnitude (saturated) or a strict threshold result comes out two accepts-cycles later.
module sobel_stream_core #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic               clk,
  input  logic               reset,
  sobel_stream_core_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DATA_W + 3;
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] PIX_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];

  logic [CW-1:0]        col_q, col_d, pos_col;
  logic [RW-1:0]        row_q, row_d, pos_row;
  logic [DATA_W-1:0]    win_q [3][3];
  logic [DATA_W-1:0]    win_d [3][3];
  logic                 s1_valid_q, s1_valid_d, s1_border_q, s1_border_d;
  logic                 s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d, s1_eof_q, s1_eof_d;
  logic                 s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d;
  logic                 s2_eol_q, s2_eol_d, s2_eof_q, s2_eof_d;
  logic [DATA_W-1:0]    s2_pix_q, s2_pix_d;
  logic                 out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic                 out_eol_q, out_eol_d, out_eof_q, out_eof_d;
  logic [DATA_W-1:0]    out_pix_q, out_pix_d;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        mag;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    return v[GW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Accept stage: raster position (sof resyncs to 0,0), counters, window shift, sideband.
  always_comb begin
    pos_col     = col_q;
    pos_row     = row_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    s1_valid_d  = 1'b0;
    s1_sof_d    = 1'b0;
    s1_eol_d    = 1'b0;
    s1_eof_d    = 1'b0;
    s1_border_d = 1'b1;
    if (bus.in_sof) begin
      pos_col = {CW{1'b0}};
      pos_row = {RW{1'b0}};
    end else begin
      pos_col = col_q;
      pos_row = row_q;
    end
    if (bus.in_valid) begin
      if (pos_col == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (pos_row == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = pos_row + 1'b1;
        end
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_mem[pos_col];
      win_d[1][2] = lb0_mem[pos_col];
      win_d[2][2] = bus.in_pix;
      s1_valid_d  = 1'b1;
      s1_sof_d    = (pos_col == {CW{1'b0}}) && (pos_row == {RW{1'b0}});
      s1_eol_d    = (pos_col == COL_LAST);
      s1_eof_d    = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
      // Rows 0-1 and cols 0-1 would pull stale RAM/window contents into the kernel.
      s1_border_d = (pos_row < RW'(2)) || (pos_col < CW'(2));
    end else begin
      s1_valid_d = 1'b0;
    end
  end

  // Compute stage (mode/thresh sampled here) and the registered output stage.
  always_comb begin
    gx = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
       - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
    mag        = abs_val(gx) + abs_val(gy);
    s2_valid_d = s1_valid_q;
    s2_sof_d   = s1_valid_q & s1_sof_q;
    s2_eol_d   = s1_valid_q & s1_eol_q;
    s2_eof_d   = s1_valid_q & s1_eof_q;
    s2_pix_d   = s2_pix_q;
    if (!s1_valid_q) begin
      s2_pix_d = s2_pix_q;
    end else if (s1_border_q) begin
      s2_pix_d = PIX_ZERO;
    end else if (bus.mode) begin
      s2_pix_d = (mag > {3'b000, bus.thresh}) ? PIX_MAX : PIX_ZERO;
    end else if (|mag[GW-1:DATA_W]) begin
      s2_pix_d = PIX_MAX;
    end else begin
      s2_pix_d = mag[DATA_W-1:0];
    end
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_sof_q;
    out_eol_d   = s2_eol_q;
    out_eof_d   = s2_eof_q;
    if (s2_valid_q) begin
      out_pix_d = s2_pix_q;
    end else begin
      out_pix_d = out_pix_q;
    end
  end

  // Line buffers: old lb0 entry moves up to lb1 while the new pixel lands in lb0.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !reset) begin
      lb1_mem[pos_col] <= lb0_mem[pos_col];
      lb0_mem[pos_col] <= bus.in_pix;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= PIX_ZERO;
        end
      end
      s1_valid_q  <= 1'b0;
      s1_border_q <= 1'b1;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_eol_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      s2_pix_q    <= PIX_ZERO;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pix_q   <= PIX_ZERO;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      s1_valid_q  <= s1_valid_d;
      s1_border_q <= s1_border_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      s1_eof_q    <= s1_eof_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_eol_q    <= s2_eol_d;
      s2_eof_q    <= s2_eof_d;
      s2_pix_q    <= s2_pix_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      out_pix_q   <= out_pix_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;
endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core on an 8x6 image: image-array Sobel reference model with a
// timed expectation queue checked every cycle, plus literal pins on flat/step frames.
module tb_sobel_stream_core;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic reset;
  sobel_stream_core_if #(.DATA_W(DW)) bus ();

  sobel_stream_core #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         r;
    int         c;
    logic [7:0] pix;
    bit         sof;
    bit         eol;
    bit         eof;
  } exp_t;

  exp_t       expq[$];
  exp_t       pend_e;
  exp_t       ce;
  bit         pend_v = 1'b0;
  int         pend_mag;
  bit         pend_border;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         rst_cyc = -1;
  int         mr = 0;
  int         mc = 0;
  logic [7:0] img [H][W];
  logic [7:0] mdl_img [H][W];
  logic [7:0] last_pix = 8'd0;
  int         tot_cnt = 0, tot_nz = 0, tot_eol = 0, eof_at = -1;
  int         base_cnt, base_nz, base_eol;
  bit         rand_ctl = 1'b0;
  int         kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int         ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int sobel_mag(input int r, input int c);
    int gx, gy, v;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v  = int'(img[r-2+i][c-2+j]);
        gx += kx[i][j] * v;
        gy += ky[i][j] * v;
      end
    end
    return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
  endfunction

  // Reference model: the pixel accepted at edge k is finished at edge k+1 with the
  // mode/thresh present then, and must appear after edge k+2.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      expq.delete();
      pend_v  = 1'b0;
      mr      = 0;
      mc      = 0;
      rst_cyc = cyc;
    end else begin
      if (pend_v) begin
        if (pend_border) pend_e.pix = 8'd0;
        else if (bus.mode) pend_e.pix = (pend_mag > int'(bus.thresh)) ? 8'd255 : 8'd0;
        else pend_e.pix = (pend_mag > 255) ? 8'd255 : 8'(pend_mag);
        mdl_img[pend_e.r][pend_e.c] = pend_e.pix;
        expq.push_back(pend_e);
        pend_v = 1'b0;
      end
      if (bus.in_valid) begin
        if (bus.in_sof) begin
          mr = 0;
          mc = 0;
        end
        img[mr][mc] = bus.in_pix;
        pend_e.due  = cyc + 2;
        pend_e.r    = mr;
        pend_e.c    = mc;
        pend_e.sof  = (mr == 0) && (mc == 0);
        pend_e.eol  = (mc == W - 1);
        pend_e.eof  = (mr == H - 1) && (mc == W - 1);
        pend_border = (mr < 2) || (mc < 2);
        pend_mag    = pend_border ? 0 : sobel_mag(mr, mc);
        pend_v      = 1'b1;
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
  end

  // Compare process: every cycle the outputs are either the due expectation or idle/held.
  always @(negedge clk) begin
    if (rst_cyc == cyc) last_pix = 8'd0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      ce = expq.pop_front();
      chk("out_valid", int'(bus.out_valid), 1);
      chk("out_pix", int'(bus.out_pix), int'(ce.pix));
      chk("out_sof", int'(bus.out_sof), int'(ce.sof));
      chk("out_eol", int'(bus.out_eol), int'(ce.eol));
      chk("out_eof", int'(bus.out_eof), int'(ce.eof));
      last_pix = ce.pix;
      tot_cnt++;
      if (bus.out_pix != 8'd0) tot_nz++;
      if (bus.out_eol) tot_eol++;
      if (bus.out_eof) eof_at = tot_cnt;
    end else begin
      chk("idle_valid", int'(bus.out_valid), 0);
      chk("idle_pix_hold", int'(bus.out_pix), int'(last_pix));
      chk("idle_flags", int'({bus.out_sof, bus.out_eol, bus.out_eof}), 0);
    end
  end

  task automatic drive(input bit v, input bit sof, input logic [7:0] pix);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_pix   = pix;
    if (rand_ctl) begin
      bus.mode   = 1'($urandom_range(0, 1));
      bus.thresh = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  // kind 0: flat 100, 1: vertical step of height h at col 4, 2: random
  task automatic feed(input int kind, input int h, input bit gaps, input int npix, input bit use_sof);
    logic [7:0] p;
    for (int i = 0; i < npix; i++) begin
      if (kind == 0) p = 8'd100;
      else if (kind == 1) p = ((i % W) >= 4) ? 8'(h) : 8'd0;
      else p = 8'($urandom);
      if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
      drive(1'b1, use_sof && (i == 0), p);
    end
    idle(4);
  endtask

  task automatic mark();
    base_cnt = tot_cnt;
    base_nz  = tot_nz;
    base_eol = tot_eol;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pix   = 8'd0;
    bus.mode     = 1'b0;
    bus.thresh   = 8'd0;
    reset        = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive(1'(i % 2), 1'b0, 8'($urandom));
    reset = 1'b0;

    // Flat frame straight out of reset, no in_sof: counters must already be at (0,0).
    mark();
    feed(0, 0, 1'b0, W * H, 1'b0);
    chk("flat_count", tot_cnt - base_cnt, W * H);
    chk("flat_nonzero", tot_nz - base_nz, 0);
    chk("flat_eol_count", tot_eol - base_eol, H);
    chk("flat_eof_pos", eof_at, base_cnt + W * H);

    // Step 0|255, magnitude mode: 4*255 saturates to 255 at c=4,5 for rows >= 2.
    mark();
    feed(1, 255, 1'b0, W * H, 1'b1);
    chk("step_mdl_2_4", int'(mdl_img[2][4]), 255);
    chk("step_mdl_5_5", int'(mdl_img[5][5]), 255);
    chk("step_mdl_3_3", int'(mdl_img[3][3]), 0);
    chk("step_mdl_4_6", int'(mdl_img[4][6]), 0);
    chk("step_mdl_1_4", int'(mdl_img[1][4]), 0);
    chk("step_nonzero", tot_nz - base_nz, 8);

    // Step 0|255, threshold 200.
    bus.mode   = 1'b1;
    bus.thresh = 8'd200;
    mark();
    feed(1, 255, 1'b1, W * H, 1'b1);
    chk("thr_mdl_2_5", int'(mdl_img[2][5]), 255);
    chk("thr_nonzero", tot_nz - base_nz, 8);

    // Step 0|50: magnitude exactly 200; strict compare at thresh 200 vs 199.
    bus.mode = 1'b0;
    feed(1, 50, 1'b0, W * H, 1'b1);
    chk("step50_mdl_3_4", int'(mdl_img[3][4]), 200);
    bus.mode = 1'b1;
    mark();
    feed(1, 50, 1'b0, W * H, 1'b1);
    chk("strict_eq_nonzero", tot_nz - base_nz, 0);
    bus.thresh = 8'd199;
    mark();
    feed(1, 50, 1'b0, W * H, 1'b1);
    chk("strict_below_nonzero", tot_nz - base_nz, 8);
    chk("strict_below_mdl_4_5", int'(mdl_img[4][5]), 255);

    // Random frames with gaps and per-pixel random mode/thresh.
    rand_ctl = 1'b1;
    for (int f = 0; f < 3; f++) begin
      mark();
      feed(2, 0, 1'b1, W * H, 1'b1);
      chk("rand_count", tot_cnt - base_cnt, W * H);
    end

    // Resync: partial frame then a new frame with in_sof, no reset.
    feed(2, 0, 1'b1, 13, 1'b1);
    mark();
    feed(2, 0, 1'b1, W * H, 1'b1);
    chk("resync_count", tot_cnt - base_cnt, W * H);

    // Reset mid row 3, then a fresh frame.
    rand_ctl = 1'b0;
    bus.mode = 1'b0;
    for (int i = 0; i < 3 * W + 4; i++) drive(1'b1, (i == 0), 8'($urandom));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'(i % 2), 1'b0, 8'($urandom));
    reset = 1'b0;
    idle(3);
    mark();
    feed(2, 0, 1'b1, W * H, 1'b1);
    chk("post_reset_count", tot_cnt - base_cnt, W * H);
    chk("post_reset_eol", tot_eol - base_eol, H);

    chk("drain", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
